intc_ctrl: RTL and testbench

//  Priority interrupt controller upstream of the main decoder. Latches edges from timer flag,

---
 rtl/intc_pkg.sv | 17 +
 rtl/intc_prio_enc.sv | 24 ++
 rtl/intc_ctrl.sv | 109 ++++++++++
 tb/tb_intc_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding, id width.
package intc_pkg;

  localparam int unsigned ID_W = 3;

  localparam logic [4:0] MASK_ADDR  = 5'b11000;
  localparam logic [4:0] PEND_ADDR  = 5'b11001;
  localparam logic [4:0] CAUSE_ADDR = 5'b11010;
  localparam logic [4:0] EPC_ADDR   = 5'b11011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-set-index priority encoder: index 0 has the highest priority.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int unsigned NSRC = 4
) (
  input  logic [NSRC-1:0] vec,
  output logic [ID_W-1:0] idx,
  output logic            valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intc_ctrl.sv
// Priority interrupt controller with ack/done handshake and memory-mapped registers.
// Optional EPC capture register is enabled by defining INTC_EPC_EN.
module intc_ctrl
  import intc_pkg::*;
#(
  parameter int unsigned NSRC     = 4,
  parameter logic [31:0] VEC_BASE = 32'h180,
  parameter logic [31:0] VEC_STEP = 32'h10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq,
  input  logic            we,
  input  logic [4:0]      addr,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  input  logic [31:0]     pc,
  input  logic            int_ack,
  input  logic            int_done,
  output logic            exl,
  output logic            iv,
  output logic [31:0]     vec_addr
);

  state_t            state, next_state;
  logic [NSRC-1:0]   mask, pending, irq_q;
  logic [NSRC-1:0]   rise, w1c, ack_clr, req_vec;
  logic [ID_W-1:0]   id, enc_idx;
  logic              enc_valid;
  logic              ack_take;
  logic [31:0]       epc_rd;
  logic              unused_bits;

  assign unused_bits = ^{wd, pc};

  assign rise     = irq & ~irq_q;
  assign w1c      = (we && addr == PEND_ADDR) ? wd[NSRC-1:0] : '0;
  assign ack_take = (state == REQ) && int_ack;
  assign ack_clr  = ack_take ? (NSRC'(1) << id) : '0;
  assign req_vec  = pending & mask;

  intc_prio_enc #(.NSRC(NSRC)) u_prio_enc (
    .vec   (req_vec),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // Edge capture, pending/mask registers and id latch; a new rise beats any clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= '0;
      id      <= '0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~w1c & ~ack_clr) | rise;
      if (we && addr == MASK_ADDR) mask <= wd[NSRC-1:0];
      if (state == IDLE && enc_valid) id <= enc_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enc_valid) next_state = REQ;
      REQ:     if (int_ack)   next_state = SERVICE;
      SERVICE: if (int_done)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    exl      = (state == REQ) || (state == SERVICE);
    iv       = exl && (id != '0);
    vec_addr = VEC_BASE + 32'(id) * VEC_STEP;
  end

`ifdef INTC_EPC_EN
  logic [31:0] epc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           epc <= '0;
    else if (ack_take) epc <= pc;
  end

  assign epc_rd = epc;
`else
  assign epc_rd = '0;
`endif

  // Register read port, combinational from addr.
  always_comb begin
    rd = '0;
    case (addr)
      MASK_ADDR:  rd = 32'(mask);
      PEND_ADDR:  rd = 32'(pending);
      CAUSE_ADDR: rd = {state == SERVICE, state == REQ, 27'b0, id};
      EPC_ADDR:   rd = epc_rd;
      default:    rd = '0;
    endcase
  end

endmodule

// File: tb/tb_intc_ctrl.sv
// Directed self-checking bench for intc_ctrl (default NSRC=4 configuration).
module tb_intc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [31:0] pc;
  logic        int_ack;
  logic        int_done;
  logic        exl;
  logic        iv;
  logic [31:0] vec_addr;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [4:0] A_MASK  = 5'b11000;
  localparam logic [4:0] A_PEND  = 5'b11001;
  localparam logic [4:0] A_CAUSE = 5'b11010;
  localparam logic [4:0] A_EPC   = 5'b11011;

  intc_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .we       (we),
    .addr     (addr),
    .wd       (wd),
    .rd       (rd),
    .pc       (pc),
    .int_ack  (int_ack),
    .int_done (int_done),
    .exl      (exl),
    .iv       (iv),
    .vec_addr (vec_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rd, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wd = d;
    tick();
    we = 1'b0; wd = '0;
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    irq = v;
    tick();
    irq = '0;
  endtask

  task automatic ack(input logic [31:0] p);
    pc = p; int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic done();
    int_done = 1'b1;
    tick();
    int_done = 1'b0;
  endtask

  initial begin
    logic [31:0] epc_exp;
`ifdef INTC_EPC_EN
    epc_exp = 32'h44;
`else
    epc_exp = 32'h0;
`endif
    rst = 1'b1; irq = '0; we = 1'b0; addr = '0; wd = '0; pc = '0;
    int_ack = 1'b0; int_done = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_exl", 32'(exl), 32'h0);
    check("rst_iv", 32'(iv), 32'h0);
    check("rst_vec", vec_addr, 32'h180);
    check_rd("rst_mask", A_MASK, 32'h0);
    check_rd("rst_pend", A_PEND, 32'h0);
    check_rd("rst_cause", A_CAUSE, 32'h0);
    check_rd("unmapped", 5'b00011, 32'h0);

    // 1: single vectored source
    wr(A_MASK, 32'h2);
    pulse_irq(4'b0010);
    check("t1_exl_early", 32'(exl), 32'h0);
    tick();
    check("t1_exl", 32'(exl), 32'h1);
    check("t1_iv", 32'(iv), 32'h1);
    check("t1_vec", vec_addr, 32'h190);
    check_rd("t1_cause_req", A_CAUSE, 32'h4000_0001);
    ack(32'h10);
    check_rd("t1_cause_svc", A_CAUSE, 32'h8000_0001);
    check_rd("t1_pend", A_PEND, 32'h0);
    done();
    check("t1_exl_off", 32'(exl), 32'h0);

    // 2: masked source stays pending until enabled
    wr(A_MASK, 32'h0);
    pulse_irq(4'b0100);
    tick(); tick();
    check("t2_exl_masked", 32'(exl), 32'h0);
    check_rd("t2_pend", A_PEND, 32'h4);
    wr(A_MASK, 32'h4);
    check("t2_exl_next", 32'(exl), 32'h0);
    tick();
    check("t2_exl", 32'(exl), 32'h1);
    check("t2_vec", vec_addr, 32'h1A0);

    // 4: no preemption in REQ, ack captures pc and clears only pending[id]
    irq = 4'b0001;
    wr(A_MASK, 32'hF);
    irq = '0;
    tick();
    check_rd("t4_cause", A_CAUSE, 32'h4000_0002);
    check("t4_vec", vec_addr, 32'h1A0);
    ack(32'h44);
    check_rd("t4_pend", A_PEND, 32'h1);
    check_rd("t4_epc", A_EPC, epc_exp);
    done();
    check("t4_no_b2b", 32'(exl), 32'h0);
    tick();
    check("t4_next_exl", 32'(exl), 32'h1);
    check("t4_next_iv", 32'(iv), 32'h0);
    check("t4_next_vec", vec_addr, 32'h180);
    ack(32'h0);
    done();

    // 3: simultaneous sources, lowest index first; ack+done together acts as ack only
    pulse_irq(4'b1001);
    tick();
    check("t3_iv", 32'(iv), 32'h0);
    check("t3_vec", vec_addr, 32'h180);
    check_rd("t3_cause", A_CAUSE, 32'h4000_0000);
    int_ack = 1'b1; int_done = 1'b1;
    tick();
    int_ack = 1'b0; int_done = 1'b0;
    check_rd("t3_both_pulses", A_CAUSE, 32'h8000_0000);
    check_rd("t3_pend", A_PEND, 32'h8);
    done();
    tick();
    check("t3_id3_exl", 32'(exl), 32'h1);
    check("t3_id3_vec", vec_addr, 32'h1B0);
    check_rd("t3_id3_cause", A_CAUSE, 32'h4000_0003);
    ack(32'h0);
    done();
    check_rd("t3_pend_empty", A_PEND, 32'h0);

    // 5: rise beats W1C on the same bit
    wr(A_MASK, 32'h0);
    pulse_irq(4'b0010);
    tick();
    check_rd("t5_pend_set", A_PEND, 32'h2);
    irq = 4'b0010;
    wr(A_PEND, 32'h2);
    irq = '0;
    check_rd("t5_set_wins", A_PEND, 32'h2);
    wr(A_PEND, 32'h2);
    check_rd("t5_w1c", A_PEND, 32'h0);

    // 6: async reset in SERVICE
    wr(A_MASK, 32'h2);
    pulse_irq(4'b0110);
    tick();
    ack(32'h80);
    check("t6_exl_svc", 32'(exl), 32'h1);
    check_rd("t6_pend", A_PEND, 32'h4);
    rst = 1'b1;
    #1;
    check("t6_rst_exl", 32'(exl), 32'h0);
    check_rd("t6_rst_pend", A_PEND, 32'h0);
    check_rd("t6_rst_mask", A_MASK, 32'h0);
    tick();
    rst = 1'b0;
    done();
    check("t6_done_ignored", 32'(exl), 32'h0);
    check_rd("t6_cause", A_CAUSE, 32'h0);
    ack(32'h0);
    check_rd("t6_ack_ignored", A_CAUSE, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
